// File: rtl/ahb_gpio_bank.sv
// ahb_gpio_bank
// -----------------------------------------------------------------------------
// AHB-Lite GPIO bank with GPIO_W pins. Each pin has an output data bit (OUT)
// and a direction bit (DIR). Outputs can be updated atomically through the
// SET/CLR/TGL aliases. Pin inputs pass through a SYNC_STAGES-deep
// synchroniser. The synchronised value feeds per-bit rise/fall edge detectors.
// Detected edges are latched in IRQ_STAT (write-1-to-clear), and irq is the
// OR of all IRQ_STAT bits.
//
// Register map (offset = HADDR[7:0]):
//   0x00 OUT      RW   0x04 IN       RO   0x08 DIR      RW
//   0x0C SET      WO   0x10 CLR      WO   0x14 TGL      WO
//   0x18 RISE_EN  RW   0x1C FALL_EN  RW   0x20 IRQ_STAT R/W1C
//
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS  AHB-Lite address phase (HSIZE/HPROT are ignored)
//   HWRITE, HWDATA       write direction and data-phase write data
//   HREADY               bus ready in; HREADYOUT is always 1 (no wait states)
//   HRDATA, HRESP        read data (0 outside a read data phase), always OKAY
//   gpio_out, gpio_oe    pin output data and per-pin output enable
//   gpio_in              asynchronous pin inputs
//   irq                  level interrupt, OR of IRQ_STAT
// -----------------------------------------------------------------------------
module ahb_gpio_bank #(
  parameter int unsigned GPIO_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [3:0]        HPROT,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);

  localparam logic [7:0] OFF_OUT   = 8'h00;
  localparam logic [7:0] OFF_IN    = 8'h04;
  localparam logic [7:0] OFF_DIR   = 8'h08;
  localparam logic [7:0] OFF_SET   = 8'h0C;
  localparam logic [7:0] OFF_CLR   = 8'h10;
  localparam logic [7:0] OFF_TGL   = 8'h14;
  localparam logic [7:0] OFF_RISE  = 8'h18;
  localparam logic [7:0] OFF_FALL  = 8'h1C;
  localparam logic [7:0] OFF_STAT  = 8'h20;

  localparam int unsigned CHAIN_W = SYNC_STAGES * GPIO_W;

  // Address-phase capture
  logic              xfer_accept;
  logic [7:0]        addr_reg;
  logic              rd_reg;
  logic              wr_reg;

  // Programmer-visible state
  logic [GPIO_W-1:0] out_reg,      out_next;
  logic [GPIO_W-1:0] dir_reg,      dir_next;
  logic [GPIO_W-1:0] rise_en_reg,  rise_en_next;
  logic [GPIO_W-1:0] fall_en_reg,  fall_en_next;
  logic [GPIO_W-1:0] irq_stat_reg, irq_stat_next;

  // Input synchroniser: newest sample in the low slice, oldest in the top slice
  logic [CHAIN_W-1:0] sync_chain_reg;
  logic [GPIO_W-1:0]  sync_val;
  logic [GPIO_W-1:0]  sync_d_reg;
  logic [GPIO_W-1:0]  edge_evt;

  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] w1c_mask;
  logic [GPIO_W-1:0] rd_val;

  // Transfer attributes, width and protection carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HPROT, HADDR[31:8], HTRANS[0], HWDATA};

  assign xfer_accept = HSEL & HTRANS[1] & HREADY;
  assign wdata       = HWDATA[GPIO_W-1:0];

  // ---------------------------------------------------------------------------
  // Address phase: flags last exactly one data phase unless re-armed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_reg <= '0;
      rd_reg   <= 1'b0;
      wr_reg   <= 1'b0;
    end else begin
      rd_reg <= xfer_accept & ~HWRITE;
      wr_reg <= xfer_accept & HWRITE;
      if (xfer_accept) begin
        addr_reg <= HADDR[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser and one-cycle delayed copy for edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_chain_reg <= '0;
      sync_d_reg     <= '0;
    end else begin
      sync_chain_reg <= {sync_chain_reg[CHAIN_W-GPIO_W-1:0], gpio_in};
      sync_d_reg     <= sync_val;
    end
  end

  assign sync_val = sync_chain_reg[CHAIN_W-1 -: GPIO_W];

  genvar gi;
  generate
    for (gi = 0; gi < GPIO_W; gi++) begin : g_edge
      assign edge_evt[gi] = (sync_val[gi] & ~sync_d_reg[gi] & rise_en_reg[gi])
                          | (~sync_val[gi] & sync_d_reg[gi] & fall_en_reg[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Data-phase write decode. The write lands on the edge that closes the data
  // phase, so a read in the following data phase already sees it.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_next     = out_reg;
    dir_next     = dir_reg;
    rise_en_next = rise_en_reg;
    fall_en_next = fall_en_reg;
    w1c_mask     = '0;
    if (wr_reg) begin
      case (addr_reg)
        OFF_OUT:  out_next     = wdata;
        OFF_DIR:  dir_next     = wdata;
        OFF_SET:  out_next     = out_reg | wdata;
        OFF_CLR:  out_next     = out_reg & ~wdata;
        OFF_TGL:  out_next     = out_reg ^ wdata;
        OFF_RISE: rise_en_next = wdata;
        OFF_FALL: fall_en_next = wdata;
        OFF_STAT: w1c_mask     = wdata;
        default:  ;
      endcase
    end
    // A new edge takes priority over a same-cycle clear of that bit.
    irq_stat_next = (irq_stat_reg & ~w1c_mask) | edge_evt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_reg      <= '0;
      dir_reg      <= '0;
      rise_en_reg  <= '0;
      fall_en_reg  <= '0;
      irq_stat_reg <= '0;
    end else begin
      out_reg      <= out_next;
      dir_reg      <= dir_next;
      rise_en_reg  <= rise_en_next;
      fall_en_reg  <= fall_en_next;
      irq_stat_reg <= irq_stat_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: combinational from the registered address, zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (addr_reg)
      OFF_OUT:  rd_val = out_reg;
      OFF_IN:   rd_val = sync_val;
      OFF_DIR:  rd_val = dir_reg;
      OFF_RISE: rd_val = rise_en_reg;
      OFF_FALL: rd_val = fall_en_reg;
      OFF_STAT: rd_val = irq_stat_reg;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    if (rd_reg) begin
      HRDATA[GPIO_W-1:0] = rd_val;
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign gpio_out  = out_reg;
  assign gpio_oe   = dir_reg;
  assign irq       = |irq_stat_reg;

endmodule

// File: tb/tb_ahb_gpio_bank.sv
// tb_ahb_gpio_bank
// Directed and randomised stimulus for ahb_gpio_bank (GPIO_W=8, SYNC_STAGES=2).
// Expected values come from fixed constants and from a behavioural model of
// the register file, pin history and interrupt status.
module tb_ahb_gpio_bank;

  localparam int GPIO_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [3:0]        HPROT;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [31:0]       HRDATA;
  logic              HRESP;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;
  logic [GPIO_W-1:0] gpio_in;
  logic              irq;

  int n_checks = 0;
  int n_errors = 0;

  ahb_gpio_bank #(.GPIO_W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .gpio_in(gpio_in), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural model state
  logic [GPIO_W-1:0] m_out, m_dir, m_rise, m_fall, m_stat;
  logic [GPIO_W-1:0] m_hist [0:SYNC_STAGES];  // m_hist[0] = pins at latest edge
  logic              m_wr, m_rd;
  logic [7:0]        m_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    m_wr = 1'b0; m_rd = 1'b0; m_addr = '0;
    for (int k = 0; k <= SYNC_STAGES; k++) m_hist[k] = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [GPIO_W-1:0] v;
    case (a)
      8'h00:   v = m_out;
      8'h04:   v = m_hist[SYNC_STAGES-1];
      8'h08:   v = m_dir;
      8'h18:   v = m_rise;
      8'h1C:   v = m_fall;
      8'h20:   v = m_stat;
      default: v = '0;
    endcase
    return 32'(v);
  endfunction

  // Advance the model over one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [GPIO_W-1:0] cur, prev, ev, wd;
    logic acc;
    cur  = m_hist[SYNC_STAGES-1];
    prev = m_hist[SYNC_STAGES];
    ev   = (cur & ~prev & m_rise) | (~cur & prev & m_fall);
    wd   = HWDATA[GPIO_W-1:0];
    if (m_wr) begin
      case (m_addr)
        8'h00: m_out  = wd;
        8'h08: m_dir  = wd;
        8'h0C: m_out  = m_out | wd;
        8'h10: m_out  = m_out & ~wd;
        8'h14: m_out  = m_out ^ wd;
        8'h18: m_rise = wd;
        8'h1C: m_fall = wd;
        8'h20: m_stat = m_stat & ~wd;
        default: ;
      endcase
    end
    m_stat = m_stat | ev;
    for (int k = SYNC_STAGES; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = gpio_in;
    acc  = HSEL & HTRANS[1] & HREADY;
    m_wr = acc & HWRITE;
    m_rd = acc & ~HWRITE;
    if (acc) m_addr = HADDR[7:0];
  endtask

  task automatic cycle();
    if (HRESETn) model_edge(); else model_reset();
    @(posedge HCLK);
    #1;
    chk("gpio_out", 32'(gpio_out), 32'(m_out));
    chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
    chk("irq", 32'(irq), 32'(|m_stat));
    chk("hrdata", HRDATA, m_rd ? m_read(m_addr) : 32'h0);
    chk("hreadyout", 32'(HREADYOUT), 32'd1);
    chk("hresp", 32'(HRESP), 32'd0);
  endtask

  task automatic addr_phase(input logic [7:0] a, input logic w);
    logic [31:0] r;
    r = $urandom();
    HSEL = 1'b1; HTRANS = {1'b1, r[0]}; HREADY = 1'b1; HWRITE = w;
    HADDR = {r[31:8], a}; HSIZE = r[3:1]; HPROT = r[7:4];
  endtask

  task automatic bus_idle();
    logic [31:0] r;
    r = $urandom();
    HSEL = r[0]; HTRANS = {1'b0, r[1]}; HREADY = 1'b1; HWRITE = r[2]; HADDR = r;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    cycle();
    bus_idle();
    HWDATA = d;
    cycle();
  endtask

  task automatic read_reg(input logic [7:0] a, input logic [31:0] exp, input string tag);
    addr_phase(a, 1'b0);
    cycle();
    bus_idle();
    chk(tag, HRDATA, exp);
    cycle();
  endtask

  function automatic logic [7:0] rand_off();
    int unsigned idx;
    idx = $urandom_range(0, 10);
    if (idx <= 9) return 8'(idx * 4);
    return 8'hC4;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = '0; HSIZE = '0; HPROT = '0;
    HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1; gpio_in = '0;
    model_reset();
    repeat (3) cycle();
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    HRESETn = 1'b1;
    cycle();

    // Every offset reads 0 after reset
    for (int a = 0; a <= 32'h20; a += 4) read_reg(8'(a), 32'h0, "rst_read");

    // Output writes and atomic aliases
    write_reg(8'h00, 32'hDEAD_00A5); chk("out_write", 32'(gpio_out), 32'hA5);
    write_reg(8'h0C, 32'h0000_000A); chk("out_set", 32'(gpio_out), 32'hAF);
    write_reg(8'h10, 32'h0000_0081); chk("out_clr", 32'(gpio_out), 32'h2E);
    write_reg(8'h14, 32'h0000_00FF); chk("out_tgl", 32'(gpio_out), 32'hD1);
    read_reg(8'h00, 32'hD1, "out_read");
    read_reg(8'h0C, 32'h0, "set_reads_0");
    read_reg(8'h10, 32'h0, "clr_reads_0");
    read_reg(8'h14, 32'h0, "tgl_reads_0");
    read_reg(8'h24, 32'h0, "unmapped_reads_0");

    // Read data phase directly after a write data phase
    addr_phase(8'h00, 1'b1);
    cycle();
    HWDATA = 32'h0000_003C;
    addr_phase(8'h00, 1'b0);
    cycle();
    bus_idle();
    chk("b2b_read", HRDATA, 32'h3C);
    cycle();

    // Direction register and read-only IN
    write_reg(8'h08, 32'h0000_000F); chk("dir_write", 32'(gpio_oe), 32'h0F);
    write_reg(8'h08, 32'h1234_FF0F); chk("dir_upper", 32'(gpio_oe), 32'h0F);
    read_reg(8'h08, 32'h0F, "dir_read");
    gpio_in = 8'h99;
    repeat (SYNC_STAGES + 1) cycle();
    write_reg(8'h04, 32'hFF);
    read_reg(8'h04, 32'h99, "in_ro");

    // Pin-to-IN latency
    for (int d = 0; d <= SYNC_STAGES; d++) begin
      gpio_in = 8'h00;
      repeat (SYNC_STAGES + 1) cycle();
      gpio_in = 8'h3C;
      repeat (d) cycle();
      addr_phase(8'h04, 1'b0);
      cycle();
      bus_idle();
      chk("in_latency", HRDATA, (d + 1 >= SYNC_STAGES) ? 32'h3C : 32'h0);
      cycle();
    end

    // Interrupt path
    gpio_in = 8'h02;
    repeat (SYNC_STAGES + 2) cycle();
    write_reg(8'h18, 32'h01);
    write_reg(8'h1C, 32'h02);
    gpio_in = 8'h05;
    for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
      cycle();
      chk("irq_latency", 32'(irq), (i == SYNC_STAGES + 1) ? 32'd1 : 32'd0);
    end
    read_reg(8'h20, 32'h03, "irq_stat");
    write_reg(8'h20, 32'h01);
    read_reg(8'h20, 32'h02, "w1c_bit0");
    chk("irq_still_set", 32'(irq), 32'd1);
    write_reg(8'h20, 32'h02);
    chk("irq_cleared", 32'(irq), 32'd0);

    // W1C coinciding with a new rising edge on the same bit
    gpio_in = 8'h04;
    repeat (SYNC_STAGES + 2) cycle();
    gpio_in = 8'h05;
    repeat (SYNC_STAGES - 1) cycle();
    write_reg(8'h20, 32'h01);
    read_reg(8'h20, 32'h01, "set_wins");
    chk("set_wins_irq", 32'(irq), 32'd1);
    write_reg(8'h20, 32'hFF);

    // Reset asserted during a write data phase
    write_reg(8'h00, 32'h5A);
    write_reg(8'h08, 32'h33);
    addr_phase(8'h00, 1'b1);
    cycle();
    bus_idle();
    HWDATA = 32'hFF;
    #2;
    HRESETn = 1'b0;
    model_reset();
    #1;
    chk("midrst_out", 32'(gpio_out), 32'h0);
    chk("midrst_oe", 32'(gpio_oe), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_hrdata", HRDATA, 32'h0);
    cycle();
    HRESETn = 1'b1;
    cycle();
    read_reg(8'h00, 32'h0, "midrst_out_read");
    read_reg(8'h08, 32'h0, "midrst_dir_read");
    read_reg(8'h18, 32'h0, "midrst_rise_read");

    // Randomised pipelined traffic with pin activity
    for (int it = 0; it < 400; it++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      HWDATA = $urandom();
      if ($urandom_range(0, 5) == 0) gpio_in = GPIO_W'($urandom());
      if (r < 55) begin
        addr_phase(rand_off(), $urandom_range(0, 1) == 1);
      end else if (r < 65 && !m_wr && !m_rd) begin
        addr_phase(rand_off(), $urandom_range(0, 1) == 1);
        HREADY = 1'b0;
      end else begin
        bus_idle();
      end
      cycle();
    end
    bus_idle();
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_gpio_bank.md
Name: ahb_gpio_bank

Overview:
Parametrised AHB-Lite GPIO bank and the next generation of our single-port GPIO slave. It provides GPIO_W pins, each with its own direction bit, and atomic set/clear/toggle output writes. Inputs pass through a synchroniser and feed per-bit rising/falling edge interrupts, which combine into one level irq for the system interrupt controller. The block sits on the AHB-Lite slave mux beside the existing peripherals.

Parameters:
GPIO_W, 8, number of GPIO pins (1..32)
SYNC_STAGES, 2, input synchroniser depth in flops (>=2)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  reset
HSEL  in  1  slave select
HADDR  in  32  address; only HADDR[7:0] is decoded
HTRANS  in  2  transfer type; HTRANS[1]=1 means a valid transfer
HSIZE  in  3  ignored; every access is treated as 32-bit
HPROT  in  4  ignored
HWRITE  in  1  1 = write
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready
HREADYOUT  out  1  tied to 1
HRDATA  out  32  read data
HRESP  out  1  tied to 0 (OKAY)
gpio_out  out  GPIO_W  output data
gpio_oe  out  GPIO_W  per-pin output enable (equals DIR)
gpio_in  in  GPIO_W  asynchronous pin inputs
irq  out  1  level interrupt; OR of IRQ_STAT bits

Behaviour:
- Reset: HRESETn is asynchronous and active-low; the clock is HCLK. On reset, every register is 0, so gpio_out=0, gpio_oe=0, irq=0 and all synchroniser flops are 0.
- Address phase: a transfer is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register the address HADDR[7:0], a read flag and a write flag. Both flags clear on the next cycle unless a new transfer is accepted.
- Write timing: a write uses HWDATA[GPIO_W-1:0] during the data phase. It takes effect on the HCLK edge that ends the data phase. Upper HWDATA bits are ignored.
- Read timing: HRDATA is combinational from the registered address while the read flag is high, else 0. Unmapped offsets and bits at or above GPIO_W read 0. Zero wait states.
- Register map:
  - 0x00 OUT: RW, drives gpio_out.
  - 0x04 IN: RO, synchronised input value.
  - 0x08 DIR: RW, 1 = output; drives gpio_oe.
  - 0x0C SET: WO, OUT |= wdata.
  - 0x10 CLR: WO, OUT &= ~wdata.
  - 0x14 TGL: WO, OUT ^= wdata.
  - 0x18 RISE_EN: RW.
  - 0x1C FALL_EN: RW.
  - 0x20 IRQ_STAT: read status; write 1 to clear a bit.
- Write-only offsets read 0. Writes to RO offsets and unmapped offsets have no effect.
- Back-to-back accesses: a read whose data phase follows a write's data phase returns the updated value.
- OUT is independent of DIR. Writes to OUT while DIR=0 are retained and appear on gpio_out; external logic gates pins with gpio_oe.
- Synchroniser: gpio_in passes through SYNC_STAGES flops to give sync. The IN register reads sync, so latency from pin to IN is SYNC_STAGES cycles. sync_d is sync delayed by one cycle.
- Edge detection, per bit:
  - rise = sync & ~sync_d & RISE_EN
  - fall = ~sync & sync_d & FALL_EN
  - IRQ_STAT[i] is set on the next edge when rise[i] or fall[i].
- Total latency from a pin edge to irq is SYNC_STAGES+1 cycles. irq = |IRQ_STAT and is combinational from the register.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins and the bit stays 1.
- Enable changes: disabling RISE_EN/FALL_EN does not clear pending IRQ_STAT bits. Edges that occur while a bit is disabled are not latched.
- A pin toggling faster than the synchroniser window may be missed; this is accepted.
- Reset mid-transfer: registered flags clear, so HRDATA=0 and the write is discarded.

Test Plan:
- Reset, then read every offset 0x00..0x20 -> all read 0; gpio_out=0, gpio_oe=0, irq=0.
- Write OUT=0xA5, SET=0x0A, CLR=0x81, TGL=0xFF (GPIO_W=8) -> gpio_out sequence is 0xA5, 0xAF, 0x2E, 0xD1; read of OUT returns 0xD1.
- Write DIR=0x0F, then 0x1234FF0F -> gpio_oe=0x0F, then 0x0F (upper bits dropped); write to IN at 0x04 -> IN still reflects pins.
- gpio_in goes 0x00 to 0x3C -> IN reads 0x00 through cycle SYNC_STAGES-1 and 0x3C from cycle SYNC_STAGES onward.
- Interrupt path:
  - RISE_EN=0x01, FALL_EN=0x02; pin0 rises, pin1 falls, pin2 rises -> IRQ_STAT=0x03 and irq=1 at edge+3 cycles (SYNC_STAGES=2).
  - Write IRQ_STAT=0x01 -> reads 0x02 and irq stays 1.
  - Write 0x02 -> irq=0.
- W1C of bit0 in the same cycle as a new rising edge on bit0 -> IRQ_STAT[0] stays 1. HRESETn asserted mid write data phase -> no register changes, and all outputs are 0.
